// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: FU result payload, CDB slot
// format, slot count and functional-unit indices.
package cdb_arbiter_pkg;

    localparam int NUM_CDB_PORTS = 2;
    localparam int PREG_W        = 6;
    localparam int DATA_W        = 32;
    localparam int ROB_IDX_W     = 6;

    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_DIV  = 3;
    localparam int FU_LSU  = 4;

    typedef struct packed {
        logic [PREG_W-1:0]    preg;
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob_idx;
    } fu_result_t;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    preg;
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob_idx;
    } cdb_t;

    function automatic cdb_t to_cdb(input fu_result_t r);
        cdb_t c;
        c.valid   = 1'b1;
        c.preg    = r.preg;
        c.data    = r.data;
        c.rob_idx = r.rob_idx;
        return c;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-side handshake and CDB broadcast bundle; the arbiter is the slave,
// the FU/consumer side is the master.
interface cdb_arbiter_if #(parameter int NUM_FU = 5) ();
    import cdb_arbiter_pkg::*;

    logic                flush;
    logic [NUM_FU-1:0]   fu_valid;
    fu_result_t          fu_result [NUM_FU];
    logic [NUM_FU-1:0]   fu_ready;
    cdb_t                cdb [NUM_CDB_PORTS];

    modport master (
        output flush,
        output fu_valid,
        output fu_result,
        input  fu_ready,
        input  cdb
    );

    modport slave (
        input  flush,
        input  fu_valid,
        input  fu_result,
        output fu_ready,
        output cdb
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer. Pointers carry one extra bit; storage is indexed by the
// low bits so wrap-around is mod DEPTH. Flush empties the buffer and drops a push.
module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fu_result_t                 i_data,
    input  logic                       i_pop,
    output fu_result_t                 o_head,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fu_result_t      r_mem [DEPTH];
    logic [CW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_CDB_PORTS FU buffer heads per cycle
// into registered CDB slots. Define CDB_ARB_BYPASS_EN to let an empty buffer's push go straight to the CDB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    cdb_arbiter_if.slave   bus
);
    localparam int PW = $clog2(NUM_FU);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [PW-1:0]              r_rr_ptr;
    cdb_t                       r_cdb [NUM_CDB_PORTS];

    fu_result_t                 w_head [NUM_FU];
    logic [CW-1:0]              w_count [NUM_FU];
    logic [NUM_FU-1:0]          w_empty;
    logic [NUM_FU-1:0]          w_full;
    logic [NUM_FU-1:0]          w_xfer;
    logic [NUM_FU-1:0]          w_elig;
    logic [NUM_FU-1:0]          w_grant;
    logic [NUM_FU-1:0]          w_bypass;
    logic [NUM_FU-1:0]          w_push;
    logic [NUM_FU-1:0]          w_pop;
    logic [NUM_CDB_PORTS-1:0]   w_slot_vld;
    logic [PW-1:0]              w_slot_src [NUM_CDB_PORTS];
    fu_result_t                 w_slot_res [NUM_CDB_PORTS];
    logic [PW-1:0]              w_last;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign w_empty[i] = (w_count[i] == '0);
        assign w_full[i]  = (w_count[i] == CW'(BUF_DEPTH));

        cdb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_flush (bus.flush),
            .i_push  (w_push[i]),
            .i_data  (bus.fu_result[i]),
            .i_pop   (w_pop[i]),
            .o_head  (w_head[i]),
            .o_count (w_count[i])
        );
    end

    assign bus.fu_ready = ~w_full;
    assign w_xfer       = bus.fu_valid & ~w_full;

`ifdef CDB_ARB_BYPASS_EN
    assign w_elig = ~w_empty | w_xfer;
`else
    assign w_elig = ~w_empty;
`endif

    // A grant on an empty buffer can only come from the bypass path.
    assign w_bypass = w_grant & w_empty;
    assign w_push   = w_xfer & ~w_bypass;
    assign w_pop    = w_grant & ~w_empty;

    always_comb begin
        logic [PW:0] sum;
        logic        placed;
        w_grant    = '0;
        w_slot_vld = '0;
        w_last     = '0;
        sum        = '0;
        placed     = 1'b0;
        for (int s = 0; s < NUM_CDB_PORTS; s++) w_slot_src[s] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_FU)) sum = sum - (PW+1)'(NUM_FU);
            if (w_elig[sum[PW-1:0]] && !(&w_slot_vld)) begin
                w_grant[sum[PW-1:0]] = 1'b1;
                w_last               = sum[PW-1:0];
                placed               = 1'b0;
                for (int s = 0; s < NUM_CDB_PORTS; s++) begin
                    if (!placed && !w_slot_vld[s]) begin
                        w_slot_vld[s] = 1'b1;
                        w_slot_src[s] = sum[PW-1:0];
                        placed        = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_CDB_PORTS; s++) begin
`ifdef CDB_ARB_BYPASS_EN
            w_slot_res[s] = w_empty[w_slot_src[s]] ? bus.fu_result[w_slot_src[s]]
                                                   : w_head[w_slot_src[s]];
`else
            w_slot_res[s] = w_head[w_slot_src[s]];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            for (int s = 0; s < NUM_CDB_PORTS; s++) r_cdb[s] <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < NUM_CDB_PORTS; s++) r_cdb[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_CDB_PORTS; s++) begin
                r_cdb[s] <= w_slot_vld[s] ? to_cdb(w_slot_res[s]) : '0;
            end
            if (|w_grant) begin
                r_rr_ptr <= (w_last == PW'(NUM_FU - 1)) ? '0 : w_last + 1'b1;
            end
        end
    end

    for (genvar s = 0; s < NUM_CDB_PORTS; s++) begin : g_cdb
        assign bus.cdb[s] = r_cdb[s];
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model checked every
// cycle, plus directed literal scenarios and a randomized phase.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NUM_FU = 5;
    localparam int DEPTH  = 2;
`ifdef CDB_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .BUF_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per FU, rotation pointer as a plain integer.
    fu_result_t mq [NUM_FU][$];
    int         m_rr;
    cdb_t       exp_cdb [NUM_CDB_PORTS];

    always @(posedge clk or posedge rst) begin
        bit xfer [NUM_FU];
        int n;
        int last;
        int f;
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0;
            for (int k = 0; k < NUM_CDB_PORTS; k++) exp_cdb[k] = '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            for (int k = 0; k < NUM_CDB_PORTS; k++) exp_cdb[k] = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) xfer[i] = bus.fu_valid[i] && (mq[i].size() < DEPTH);
            for (int k = 0; k < NUM_CDB_PORTS; k++) exp_cdb[k] = '0;
            n = 0;
            last = 0;
            for (int k = 0; k < NUM_FU; k++) begin
                f = (m_rr + k) % NUM_FU;
                if (n < NUM_CDB_PORTS) begin
                    fu_result_t r;
                    bit got;
                    got = 0;
                    r = '0;
                    if (mq[f].size() > 0) begin
                        r = mq[f].pop_front();
                        got = 1;
                    end
`ifdef CDB_ARB_BYPASS_EN
                    else if (xfer[f]) begin
                        r = bus.fu_result[f];
                        xfer[f] = 0;
                        got = 1;
                    end
`endif
                    if (got) begin
                        exp_cdb[n].valid   = 1'b1;
                        exp_cdb[n].preg    = r.preg;
                        exp_cdb[n].data    = r.data;
                        exp_cdb[n].rob_idx = r.rob_idx;
                        n++;
                        last = f;
                    end
                end
            end
            for (int i = 0; i < NUM_FU; i++) if (xfer[i]) mq[i].push_back(bus.fu_result[i]);
            if (n > 0) m_rr = (last + 1) % NUM_FU;
        end
    end

    bit          mon_en = 0;
    logic [28:0] fu0_next;
    bit          saw_fu0_stall;

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CDB_PORTS; k++) begin
                check("model_cdb_valid", 64'(bus.cdb[k].valid), 64'(exp_cdb[k].valid));
                if (exp_cdb[k].valid) begin
                    check("model_cdb_preg", 64'(bus.cdb[k].preg), 64'(exp_cdb[k].preg));
                    check("model_cdb_data", 64'(bus.cdb[k].data), 64'(exp_cdb[k].data));
                    check("model_cdb_rob", 64'(bus.cdb[k].rob_idx), 64'(exp_cdb[k].rob_idx));
                end
            end
            for (int i = 0; i < NUM_FU; i++)
                check("model_fu_ready", 64'(bus.fu_ready[i]), 64'(mq[i].size() < DEPTH));
            if (mon_en) begin
                if (!bus.fu_ready[0]) saw_fu0_stall = 1;
                for (int k = 0; k < NUM_CDB_PORTS; k++) begin
                    if (bus.cdb[k].valid && bus.cdb[k].data[31:29] == 3'd0) begin
                        check("fu0_order", 64'(bus.cdb[k].data[28:0]), 64'(fu0_next));
                        fu0_next = fu0_next + 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush    = 1'b0;
        bus.fu_valid = '0;
        for (int i = 0; i < NUM_FU; i++) bus.fu_result[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_res(input int i, input logic [5:0] p, input logic [31:0] d, input logic [5:0] r);
        bus.fu_result[i].preg    = p;
        bus.fu_result[i].data    = d;
        bus.fu_result[i].rob_idx = r;
    endtask

    logic [28:0]       seq [NUM_FU];
    logic [NUM_FU-1:0] acc;

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        check("reset_ready", 64'(bus.fu_ready), 64'h1f);
        check("reset_cdb0_valid", 64'(bus.cdb[0].valid), 64'd0);
        check("reset_cdb1_valid", 64'(bus.cdb[1].valid), 64'd0);
        check("reset_cdb0_payload", 64'(bus.cdb[0].data), 64'd0);
        do_reset();
        repeat (3) begin
            tick();
            check("idle_ready", 64'(bus.fu_ready), 64'h1f);
            check("idle_valid", 64'({bus.cdb[1].valid, bus.cdb[0].valid}), 64'd0);
        end

        // single push from FU2
        bus.fu_valid[FU_MUL] = 1'b1;
        set_res(FU_MUL, 6'd40, 32'hDEADBEEF, 6'd3);
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            check("single_valid0", 64'(bus.cdb[0].valid), 64'(c == LAT));
            check("single_valid1", 64'(bus.cdb[1].valid), 64'd0);
            if (c == LAT) begin
                check("single_preg", 64'(bus.cdb[0].preg), 64'd40);
                check("single_data", 64'(bus.cdb[0].data), 64'hDEADBEEF);
            end
            tick();
        end

        // all five push together, twice: second round confirms the pointer wrapped to 0
        do_reset();
        for (int round = 0; round < 2; round++) begin
            bus.fu_valid = 5'h1f;
            for (int i = 0; i < NUM_FU; i++) set_res(i, 6'(i + 1), 32'h100 + 32'(i), 6'(i));
            tick();
            idle_inputs();
            for (int c = 1; c <= LAT + 3; c++) begin
                int ph;
                ph = c - LAT;
                check("all5_valid0", 64'(bus.cdb[0].valid), 64'(ph >= 0 && ph <= 2));
                check("all5_valid1", 64'(bus.cdb[1].valid), 64'(ph >= 0 && ph <= 1));
                if (ph >= 0 && ph <= 2)
                    check("all5_data0", 64'(bus.cdb[0].data), 64'h100 + 64'(2 * ph));
                if (ph >= 0 && ph <= 1)
                    check("all5_data1", 64'(bus.cdb[1].data), 64'h101 + 64'(2 * ph));
                tick();
            end
        end

        // preg 0 result is still broadcast
        bus.fu_valid[FU_ALU1] = 1'b1;
        set_res(FU_ALU1, 6'd0, 32'h0BADF00D, 6'd17);
        tick();
        idle_inputs();
        for (int c = 1; c <= LAT; c++) begin
            if (c == LAT) begin
                check("preg0_valid", 64'(bus.cdb[0].valid), 64'd1);
                check("preg0_preg", 64'(bus.cdb[0].preg), 64'd0);
                check("preg0_rob", 64'(bus.cdb[0].rob_idx), 64'd17);
            end
            tick();
        end

        // flush with several buffers occupied; a push in the flush cycle is dropped
        do_reset();
        bus.fu_valid = 5'b00111;
        for (int i = 0; i < 3; i++) set_res(i, 6'(10 + i), 32'hA0 + 32'(i), 6'(i));
        tick();
        for (int i = 0; i < 3; i++) set_res(i, 6'(20 + i), 32'hB0 + 32'(i), 6'(i));
        tick();
        bus.fu_valid = 5'b01000;
        set_res(FU_DIV, 6'd33, 32'hC0, 6'd9);
        bus.flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_ready", 64'(bus.fu_ready), 64'h1f);
        for (int c = 0; c < 6; c++) begin
            check("flush_valid", 64'({bus.cdb[1].valid, bus.cdb[0].valid}), 64'd0);
            tick();
        end

        // FU0 streams every cycle against four other busy FUs
        do_reset();
        fu0_next = 29'd1;
        saw_fu0_stall = 0;
        mon_en = 1;
        bus.fu_valid = 5'h1f;
        for (int i = 0; i < NUM_FU; i++) begin
            seq[i] = 29'd1;
            set_res(i, 6'(i + 1), {3'(i), seq[i]}, 6'(i));
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = bus.fu_valid & bus.fu_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_FU; i++) begin
                if (acc[i]) begin
                    seq[i] = seq[i] + 1'b1;
                    bus.fu_result[i].data = {3'(i), seq[i]};
                end
            end
        end
        idle_inputs();
        repeat (10) tick();
        mon_en = 0;
        check("fu0_count", 64'(fu0_next - 1'b1), 64'(seq[0] - 1'b1));
        check("fu0_stalled", 64'(saw_fu0_stall), 64'd1);

        // async reset in the middle of traffic
        bus.fu_valid = 5'h1f;
        for (int i = 0; i < NUM_FU; i++) set_res(i, 6'(i), 32'h500 + 32'(i), 6'(i));
        repeat (3) tick();
        check("pre_rst_valid", 64'(bus.cdb[0].valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'({bus.cdb[1].valid, bus.cdb[0].valid}), 64'd0);
        check("async_rst_ready", 64'(bus.fu_ready), 64'h1f);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic with occasional flush
        for (int c = 0; c < 600; c++) begin
            bus.flush = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < NUM_FU; i++) begin
                bus.fu_valid[i] = ($urandom_range(0, 2) != 0);
                set_res(i, 6'($urandom), $urandom, 6'($urandom));
            end
            tick();
        end
        idle_inputs();
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
